// File: rtl/regfile_pkg.sv
// regfile_pkg
// Shared definitions for the multi-port register file:
//   - rf_state_e : CLEAR (sequential zeroing after reset) / RUN (normal access)
//   - RF_XLEN    : default data width
//   - rf_aw()    : address width needed to index n registers (at least 1 bit)
package regfile_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } rf_state_e;

  localparam int RF_XLEN = 32;

  // Address width for n registers; n is at least 2, so the result is at least 1
  function automatic int rf_aw(input int n);
    if (n <= 2) begin
      return 1;
    end else begin
      return $clog2(n);
    end
  endfunction

endpackage

// File: rtl/regfile_read_port.sv
// regfile_read_port
// One read port of the register file. Forces address 0, out-of-range
// addresses and not-yet-cleared contents to zero, bypasses a same-cycle
// committing write, and optionally registers the result.
// Ports:
//   clk, rst      : clock, synchronous active-low reset (output register only)
//   i_addr        : read address
//   i_ready       : array contents valid (clear engine finished)
//   i_wr_commit   : a write commits on the coming edge
//   i_wr_addr     : address of that write
//   i_wr_data     : data of that write
//   i_mem         : storage array, entries 1..NREGS-1
//   o_data        : read result (combinational or registered per READ_LAT)
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int XLEN     = RF_XLEN,
  parameter int NREGS    = 32,
  parameter int AW       = rf_aw(NREGS),
  parameter int READ_LAT = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   i_addr,
  input  logic            i_ready,
  input  logic            i_wr_commit,
  input  logic [AW-1:0]   i_wr_addr,
  input  logic [XLEN-1:0] i_wr_data,
  input  logic [XLEN-1:0] i_mem [1:NREGS-1],
  output logic [XLEN-1:0] o_data
);

  localparam logic [AW:0] LAST = (AW+1)'(NREGS - 1);

  logic            w_addr_ok;
  logic [AW-1:0]   w_idx;
  logic [XLEN-1:0] w_val;
  logic [XLEN-1:0] r_data;

  assign w_addr_ok = (i_addr != {AW{1'b0}}) && ({1'b0, i_addr} <= LAST);
  // Keep the array index inside 1..NREGS-1 even when the result is forced to 0
  assign w_idx     = w_addr_ok ? i_addr : {{(AW-1){1'b0}}, 1'b1};

  // Read value in priority order: invalid address, not ready, bypass, storage
  always_comb begin
    w_val = {XLEN{1'b0}};
    if (!w_addr_ok) begin
      w_val = {XLEN{1'b0}};
    end else if (!i_ready) begin
      w_val = {XLEN{1'b0}};
    end else if (i_wr_commit && (i_wr_addr == i_addr)) begin
      w_val = i_wr_data;
    end else begin
      w_val = i_mem[w_idx];
    end
  end

  // Output register; only observed when READ_LAT is 1
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_data <= {XLEN{1'b0}};
    end else begin
      r_data <= w_val;
    end
  end

  assign o_data = (READ_LAT == 1) ? r_data : w_val;

endmodule

// File: rtl/regfile_multiport.sv
// regfile_multiport
// Multi-port register file for the ID stage, written from WB. Register 0 is
// hardwired to zero and not stored. After reset a clear engine zeroes
// registers 1..NREGS-1 one per cycle, so the array needs no parallel reset.
// Ports:
//   clk        : clock
//   rst        : synchronous active-low reset
//   regWrite   : write enable
//   writeReg   : write address
//   writeData  : write data
//   readReg    : NREAD packed read addresses, port i at [i*AW +: AW]
//   readData   : NREAD packed read results, port i at [i*XLEN +: XLEN]
//   ready      : high once the clear engine has finished
//   wrDropped  : one-cycle pulse after a write was discarded
module regfile_multiport
  import regfile_pkg::*;
#(
  parameter int XLEN     = RF_XLEN,
  parameter int NREGS    = 32,
  parameter int NREAD    = 2,
  parameter int READ_LAT = 0,
  parameter int AW       = rf_aw(NREGS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  regWrite,
  input  logic [AW-1:0]         writeReg,
  input  logic [XLEN-1:0]       writeData,
  input  logic [NREAD*AW-1:0]   readReg,
  output logic [NREAD*XLEN-1:0] readData,
  output logic                  ready,
  output logic                  wrDropped
);

  localparam logic [AW:0] LAST = (AW+1)'(NREGS - 1);

  rf_state_e       r_state;
  logic [AW-1:0]   r_clr_cnt;
  logic            r_ready;
  logic            r_wr_dropped;
  logic [XLEN-1:0] r_mem [1:NREGS-1];

  logic w_wr_nonzero;
  logic w_wr_in_range;
  logic w_commit;
  logic w_drop;

  assign w_wr_nonzero  = (writeReg != {AW{1'b0}});
  assign w_wr_in_range = ({1'b0, writeReg} <= LAST);
  assign w_commit      = regWrite && (r_state == RUN) && w_wr_nonzero && w_wr_in_range;
  // Writes to register 0 are silently ignored, never reported as dropped
  assign w_drop        = regWrite && w_wr_nonzero && ((r_state == CLEAR) || !w_wr_in_range);

  // Clear engine FSM, ready flag and dropped-write pulse
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= CLEAR;
      r_clr_cnt    <= {{(AW-1){1'b0}}, 1'b1};
      r_ready      <= 1'b0;
      r_wr_dropped <= 1'b0;
    end else begin
      r_wr_dropped <= w_drop;
      case (r_state)
        CLEAR: begin
          r_clr_cnt <= r_clr_cnt + {{(AW-1){1'b0}}, 1'b1};
          // Leave CLEAR on the same edge that zeroes the last register
          if ({1'b0, r_clr_cnt} == LAST) begin
            r_state <= RUN;
            r_ready <= 1'b1;
          end else begin
            r_ready <= 1'b0;
          end
        end
        RUN: begin
          r_ready <= 1'b1;
        end
        default: begin
          r_state   <= CLEAR;
          r_clr_cnt <= {{(AW-1){1'b0}}, 1'b1};
          r_ready   <= 1'b0;
        end
      endcase
    end
  end

  // Storage array: zeroed by the clear engine, written by committed writes
  always_ff @(posedge clk) begin
    if (rst && (r_state == CLEAR)) begin
      r_mem[r_clr_cnt] <= {XLEN{1'b0}};
    end else if (rst && w_commit) begin
      r_mem[writeReg] <= writeData;
    end
  end

  for (genvar g = 0; g < NREAD; g++) begin : g_rd
    regfile_read_port #(
      .XLEN     (XLEN),
      .NREGS    (NREGS),
      .AW       (AW),
      .READ_LAT (READ_LAT)
    ) u_rd (
      .clk         (clk),
      .rst         (rst),
      .i_addr      (readReg[g*AW +: AW]),
      .i_ready     (r_ready),
      .i_wr_commit (w_commit),
      .i_wr_addr   (writeReg),
      .i_wr_data   (writeData),
      .i_mem       (r_mem),
      .o_data      (readData[g*XLEN +: XLEN])
    );
  end

  assign ready     = r_ready;
  assign wrDropped = r_wr_dropped;

endmodule

// File: tb/tb_regfile_multiport.sv
// Bench for regfile_multiport. Instance u_a: defaults with NREAD=4,
// combinational reads. Instance u_b: NREGS=24, NREAD=2, registered reads.
module tb_regfile_multiport;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic         a_we;
  logic [4:0]   a_waddr;
  logic [31:0]  a_wdata;
  logic [19:0]  a_raddr;
  logic [127:0] a_rdata;
  logic         a_ready;
  logic         a_drop;

  logic         b_we;
  logic [4:0]   b_waddr;
  logic [31:0]  b_wdata;
  logic [9:0]   b_raddr;
  logic [63:0]  b_rdata;
  logic         b_ready;
  logic         b_drop;

  regfile_multiport #(.NREAD(4)) u_a (
    .clk(clk), .rst(rst), .regWrite(a_we), .writeReg(a_waddr), .writeData(a_wdata),
    .readReg(a_raddr), .readData(a_rdata), .ready(a_ready), .wrDropped(a_drop)
  );

  regfile_multiport #(.NREGS(24), .NREAD(2), .READ_LAT(1)) u_b (
    .clk(clk), .rst(rst), .regWrite(b_we), .writeReg(b_waddr), .writeData(b_wdata),
    .readReg(b_raddr), .readData(b_rdata), .ready(b_ready), .wrDropped(b_drop)
  );

  typedef struct {
    logic             we;
    logic [4:0]       waddr;
    logic [31:0]      wdata;
    logic [3:0][4:0]  raddr;
    logic [3:0][31:0] rexp;
    logic             drop;
  } vec_t;

  typedef struct {
    logic [3:0][31:0] rexp;
    logic             drop;
    int               id;
  } sb_t;

  sb_t  a_q[$];
  sb_t  b_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  logic a_prev_drop = 1'b0;
  vec_t ta[10];
  vec_t tb[7];

  task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s #%0d: got %h, want %h", nm, id, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                              input logic [4:0] r0, input logic [4:0] r1,
                              input logic [4:0] r2, input logic [4:0] r3,
                              input logic [31:0] e0, input logic [31:0] e1,
                              input logic [31:0] e2, input logic [31:0] e3,
                              input logic drop);
    vec_t v;
    v.we = we; v.waddr = wa; v.wdata = wd;
    v.raddr[0] = r0; v.raddr[1] = r1; v.raddr[2] = r2; v.raddr[3] = r3;
    v.rexp[0] = e0; v.rexp[1] = e1; v.rexp[2] = e2; v.rexp[3] = e3;
    v.drop = drop;
    return v;
  endfunction

  // Combinational instance: result and prior-cycle drop compared in the same cycle
  task automatic a_step(input vec_t v, input int id);
    sb_t e;
    @(posedge clk); #1;
    a_we = v.we; a_waddr = v.waddr; a_wdata = v.wdata; a_raddr = v.raddr;
    e.rexp = v.rexp; e.drop = a_prev_drop; e.id = id;
    a_q.push_back(e);
    a_prev_drop = v.drop;
    @(negedge clk);
    e = a_q.pop_front();
    for (int p = 0; p < 4; p++) chk("a_read", e.id*4 + p, a_rdata[p*32 +: 32], e.rexp[p]);
    chk("a_wrDropped", e.id, {31'd0, a_drop}, {31'd0, e.drop});
  endtask

  task automatic b_cmp(input sb_t e);
    for (int p = 0; p < 2; p++) chk("b_read", e.id*2 + p, b_rdata[p*32 +: 32], e.rexp[p]);
    chk("b_wrDropped", e.id, {31'd0, b_drop}, {31'd0, e.drop});
  endtask

  // Registered instance: each vector's result is compared one cycle later
  task automatic b_step(input vec_t v, input int id);
    sb_t e;
    @(posedge clk); #1;
    b_we = v.we; b_waddr = v.waddr; b_wdata = v.wdata; b_raddr = {v.raddr[1], v.raddr[0]};
    e.rexp = v.rexp; e.drop = v.drop; e.id = id;
    b_q.push_back(e);
    @(negedge clk);
    if (b_q.size() > 1) b_cmp(b_q.pop_front());
  endtask

  task automatic b_flush();
    @(posedge clk); #1;
    b_we = 1'b0;
    @(negedge clk);
    if (b_q.size() > 0) b_cmp(b_q.pop_front());
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (a_ready && b_ready) break;
    end
    chk("ready_wait", 0, {30'd0, a_ready, b_ready}, 32'd3);
  endtask

  initial begin
    int first_a;
    int first_b;
    vec_t v;

    ta[0] = mk(1'b1, 5'd1,  32'hA5A5A5A5, 5'd1,  5'd1,  5'd0,  5'd2,  32'hA5A5A5A5, 32'hA5A5A5A5, 32'h0, 32'h0, 1'b0);
    ta[1] = mk(1'b0, 5'd0,  32'h0,        5'd1,  5'd2,  5'd1,  5'd31, 32'hA5A5A5A5, 32'h0, 32'hA5A5A5A5, 32'h0, 1'b0);
    ta[2] = mk(1'b1, 5'd0,  32'h12345678, 5'd0,  5'd0,  5'd1,  5'd0,  32'h0, 32'h0, 32'hA5A5A5A5, 32'h0, 1'b0);
    ta[3] = mk(1'b0, 5'd0,  32'h0,        5'd0,  5'd0,  5'd0,  5'd0,  32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
    ta[4] = mk(1'b1, 5'd2,  32'h00000001, 5'd2,  5'd3,  5'd2,  5'd2,  32'h1, 32'h0, 32'h1, 32'h1, 1'b0);
    ta[5] = mk(1'b1, 5'd3,  32'h00000002, 5'd2,  5'd3,  5'd3,  5'd1,  32'h1, 32'h2, 32'h2, 32'hA5A5A5A5, 1'b0);
    ta[6] = mk(1'b0, 5'd0,  32'h0,        5'd2,  5'd3,  5'd0,  5'd1,  32'h1, 32'h2, 32'h0, 32'hA5A5A5A5, 1'b0);
    ta[7] = mk(1'b1, 5'd31, 32'hCAFEF00D, 5'd31, 5'd30, 5'd31, 5'd1,  32'hCAFEF00D, 32'h0, 32'hCAFEF00D, 32'hA5A5A5A5, 1'b0);
    ta[8] = mk(1'b1, 5'd1,  32'h0BADC0DE, 5'd31, 5'd1,  5'd1,  5'd2,  32'hCAFEF00D, 32'h0BADC0DE, 32'h0BADC0DE, 32'h1, 1'b0);
    ta[9] = mk(1'b0, 5'd0,  32'h0,        5'd1,  5'd31, 5'd3,  5'd0,  32'h0BADC0DE, 32'hCAFEF00D, 32'h2, 32'h0, 1'b0);

    tb[0] = mk(1'b1, 5'd30, 32'hDEAD0030, 5'd30, 5'd0,  5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1);
    tb[1] = mk(1'b0, 5'd0,  32'h0,        5'd30, 5'd23, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
    tb[2] = mk(1'b1, 5'd7,  32'hDEADBEEF, 5'd0,  5'd7,  5'd0, 5'd0, 32'h0, 32'hDEADBEEF, 32'h0, 32'h0, 1'b0);
    tb[3] = mk(1'b0, 5'd0,  32'h0,        5'd7,  5'd7,  5'd0, 5'd0, 32'hDEADBEEF, 32'hDEADBEEF, 32'h0, 32'h0, 1'b0);
    tb[4] = mk(1'b1, 5'd23, 32'h00000023, 5'd23, 5'd24, 5'd0, 5'd0, 32'h00000023, 32'h0, 32'h0, 32'h0, 1'b0);
    tb[5] = mk(1'b1, 5'd24, 32'hFFFFFFFF, 5'd23, 5'd7,  5'd0, 5'd0, 32'h00000023, 32'hDEADBEEF, 32'h0, 32'h0, 1'b1);
    tb[6] = mk(1'b0, 5'd0,  32'h0,        5'd0,  5'd0,  5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);

    rst = 1'b0;
    a_we = 1'b0; a_waddr = 5'd0; a_wdata = 32'h0; a_raddr = 20'h0;
    b_we = 1'b0; b_waddr = 5'd0; b_wdata = 32'h0; b_raddr = {5'd7, 5'd3};

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_a_ready", 0, {31'd0, a_ready}, 32'd0);
    chk("rst_b_ready", 0, {31'd0, b_ready}, 32'd0);
    chk("rst_a_drop",  0, {31'd0, a_drop},  32'd0);
    chk("rst_b_rd0",   0, b_rdata[31:0],    32'd0);
    chk("rst_b_rd1",   0, b_rdata[63:32],   32'd0);
    @(posedge clk); #1;
    rst = 1'b1;

    // Clear engine timing, with a write attempted during clear
    first_a = 0;
    first_b = 0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (first_a == 0 && a_ready) first_a = n;
      if (first_b == 0 && b_ready) first_b = n;
      if (n == 2) begin
        a_we = 1'b1; a_waddr = 5'd5; a_wdata = 32'h55555555;
      end
      if (n == 3) begin
        chk("clear_wr_drop", 0, {31'd0, a_drop}, 32'd1);
        a_we = 1'b0;
      end
      if (n == 4) chk("clear_wr_drop_end", 0, {31'd0, a_drop}, 32'd0);
    end
    chk("a_clear_cycles", 0, first_a, 32'd31);
    chk("b_clear_cycles", 0, first_b, 32'd23);
    chk("a_ready_held",   0, {31'd0, a_ready}, 32'd1);

    // Every register reads zero on every port after clear
    for (int a = 0; a < 32; a++) begin
      v = mk(1'b0, 5'd0, 32'h0, 5'(a), 5'(a), 5'(a), 5'(a), 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
      a_step(v, 100 + a);
    end
    for (int a = 0; a < 24; a++) begin
      v = mk(1'b0, 5'd0, 32'h0, 5'(a), 5'(23 - a), 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
      b_step(v, 100 + a);
    end
    b_flush();

    // Table vectors
    for (int i = 0; i < 10; i++) a_step(ta[i], i);
    for (int i = 0; i < 7; i++) b_step(tb[i], i);
    b_flush();

    // Reset mid-operation
    @(posedge clk); #1;
    rst = 1'b0;
    a_we = 1'b0;
    a_raddr = {5'd3, 5'd2, 5'd3, 5'd2};
    b_raddr = {5'd7, 5'd7};
    @(posedge clk); #1;
    chk("mid_a_ready", 0, {31'd0, a_ready}, 32'd0);
    chk("mid_b_ready", 0, {31'd0, b_ready}, 32'd0);
    chk("mid_a_rd0",   0, a_rdata[31:0],  32'd0);
    chk("mid_b_rd0",   0, b_rdata[31:0],  32'd0);
    chk("mid_b_rd1",   0, b_rdata[63:32], 32'd0);
    rst = 1'b1;
    wait_ready();
    a_prev_drop = 1'b0;
    v = mk(1'b0, 5'd0, 32'h0, 5'd2, 5'd3, 5'd2, 5'd3, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
    a_step(v, 200);
    v = mk(1'b0, 5'd0, 32'h0, 5'd3, 5'd2, 5'd3, 5'd2, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
    a_step(v, 201);
    v = mk(1'b0, 5'd0, 32'h0, 5'd7, 5'd23, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
    b_step(v, 200);
    b_flush();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/regfile_multiport.md
# regfile_multiport

Parametrised successor to the single-write, two-read `RegisterFile` in the RV32IM pipeline. It provides NREAD read ports with write-through bypass and hardwired-zero register 0. After reset it runs a sequential clear engine, so the array maps onto RAM-style storage without a wide parallel reset. Read latency is selectable. The block sits in the ID stage and is written from WB.

## Interface
Parameters:
- XLEN, 32, data width in bits.
- NREGS, 32, number of architectural registers; legal range 2..64, need not be a power of two.
- NREAD, 2, number of read ports; legal range 1..4.
- READ_LAT, 0, read latency in cycles: 0 = combinational, 1 = registered.
- AW, $clog2(NREGS), address width (derived; not overridden).

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-low reset.
- regWrite  in  1  write enable.
- writeReg  in  AW  write address.
- writeData  in  XLEN  write data.
- readReg  in  NREAD*AW  read addresses; port i occupies bits [i*AW +: AW].
- readData  out  NREAD*XLEN  read data; port i occupies bits [i*XLEN +: XLEN].
- ready  out  1  high once the clear engine has finished.
- wrDropped  out  1  one-cycle pulse; a requested write was discarded.

## Operation
- FSM states: CLEAR and RUN.
- While rst=0 at a rising edge:
  - state <- CLEAR, clear counter <- 1.
  - ready <- 0, wrDropped <- 0, all registered readData <- 0.
- CLEAR state:
  - Each cycle writes 0 to register[counter], then increments counter.
  - When counter = NREGS-1 is written, state <- RUN on the same edge.
  - Clear therefore takes NREGS-1 cycles after rst rises.
- RUN state: ready=1.
- Writes:
  - A write commits at the edge when regWrite=1, state=RUN, writeReg≠0 and writeReg<NREGS.
  - regWrite=1 with writeReg=0 is silently ignored; wrDropped stays 0.
  - regWrite=1 during CLEAR sets wrDropped=1 for the next cycle.
  - regWrite=1 with writeReg≥NREGS sets wrDropped=1 for the next cycle.
- Reads, per port, in priority order:
  1. Address 0 or address ≥ NREGS returns 0.
  2. ready=0 returns 0.
  3. A same-cycle committing write to the same address returns writeData (bypass).
  4. Otherwise the stored value is returned.
- Read ports are independent. Several ports may read the same address; all receive the same value.
- Reset mid-operation: rst=0 in any state aborts and restarts CLEAR from counter=1. Contents are treated as invalid until ready returns high.

## Timing
- READ_LAT=0: readData is combinational from readReg, writeData, writeReg, regWrite and state. A write is visible the same cycle through bypass, and from storage on the following cycle.
- READ_LAT=1: the read value is computed as for READ_LAT=0 and sampled at the rising edge. readData appears one cycle after readReg is presented. Its reset value is 0.
- ready rises on the edge that writes register NREGS-1. With the defaults this is the 31st rising edge after the first edge sampling rst=1.
- wrDropped is registered: it is high in the cycle after the offending request, and low otherwise.
- There is no backpressure. Writes are never stalled, only committed or dropped.

## Structure
- Shared package `regfile_pkg`:
  - state enum {CLEAR, RUN}.
  - Default XLEN.
  - Function `rf_aw(n)` returning the address width.
- One sub-module, `regfile_read_port`:
  - Implements address decode, zero/invalid forcing, bypass compare and the optional output register.
  - Instantiated NREAD times via generate.
- Top level holds:
  - the storage array, sized NREGS-1 entries (register 0 is not stored);
  - the clear counter and FSM;
  - the wrDropped flop.

## Test plan
- Reset and clear:
  - Stimulus: rst=0 for 2 cycles, then rst=1; default parameters.
  - Required: ready=0 for exactly 31 cycles, then 1; every register reads 0 on all ports.
- Write/read with bypass, READ_LAT=0:
  - Stimulus: write 32'hA5A5A5A5 to r1 while port0 reads r1.
  - Required: port0 shows A5A5A5A5 in the same cycle; the next cycle, with regWrite=0, it still reads A5A5A5A5.
- Register 0 and out-of-range:
  - Stimulus: write 32'h12345678 to r0; then NREGS=24, write to address 30.
  - Required: r0 reads 0 and wrDropped stays 0; the address-30 write gives a wrDropped pulse and the read returns 0.
- Write during clear:
  - Stimulus: regWrite=1 to r5 two cycles after rst rises.
  - Required: wrDropped=1 the next cycle; r5 reads 0 after ready rises.
- Reset mid-operation and multi-port:
  - Stimulus: NREAD=4; write r2=32'h1, r3=32'h2; assert rst=0 for one cycle.
  - Required: ready falls on that edge; after re-clear all four ports read 0 for r2 and r3.
- Registered read, READ_LAT=1:
  - Stimulus: write r7=32'hDEADBEEF while port1 reads r7.
  - Required: port1 shows DEADBEEF one cycle later; readData is 0 during reset.
